// File: rtl/lcd_timing_pkg.sv
// ============================================================================
//  Module      : lcd_timing_pkg
//  Description : Shared timing defaults, pixel/pin types and helpers for the
//                LCD timing generator and its monitors.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lcd_timing_pkg;

    localparam int H_SYNC_DEF   = 128;
    localparam int H_BACK_DEF   = 88;
    localparam int H_ACTIVE_DEF = 800;
    localparam int H_FRONT_DEF  = 40;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BACK_DEF   = 33;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FRONT_DEF  = 10;
    localparam int COORD_W_DEF  = 11;

    typedef logic [23:0] rgb_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        rgb_t rgb;
    } lcd_pins_t;

    function automatic int cnt_width(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_sync_counter.sv
// ============================================================================
//  Module      : lcd_sync_counter
//  Description : Horizontal/vertical sweep counters with sync and active-area
//                decode; all outputs are combinational from the counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_sync_counter
    import lcd_timing_pkg::*;
#(
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BACK   = H_BACK_DEF,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FRONT  = H_FRONT_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BACK   = V_BACK_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FRONT  = V_FRONT_DEF,
    parameter int COORD_W  = COORD_W_DEF
) (
    input  logic               lcd_clk,
    input  logic               lcd_rst,
    output logic               hsync,
    output logic               vsync,
    output logic               active,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               frame_first
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int HW      = cnt_width(H_TOTAL);
    localparam int VW      = cnt_width(V_TOTAL);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_SYNC);
    localparam logic [HW-1:0] H_START    = HW'(H_SYNC + H_BACK);
    localparam logic [HW-1:0] H_ACT_LAST = HW'(H_SYNC + H_BACK + H_ACTIVE - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNC);
    localparam logic [VW-1:0] V_START    = VW'(V_SYNC + V_BACK);
    localparam logic [VW-1:0] V_ACT_LAST = VW'(V_SYNC + V_BACK + V_ACTIVE - 1);

    logic [HW-1:0] h_cnt_q, h_cnt_d, h_rel;
    logic [VW-1:0] v_cnt_q, v_cnt_d, v_rel;
    logic          h_act, v_act;

    always_ff @(posedge lcd_clk) begin
        if (lcd_rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Both counters wrap together on the last clock of the frame.
    always_comb begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
        end
    end

    always_comb begin
        h_act       = (h_cnt_q >= H_START) && (h_cnt_q <= H_ACT_LAST);
        v_act       = (v_cnt_q >= V_START) && (v_cnt_q <= V_ACT_LAST);
        h_rel       = h_cnt_q - H_START;
        v_rel       = v_cnt_q - V_START;
        hsync       = (h_cnt_q < H_SYNC_END);
        vsync       = (v_cnt_q < V_SYNC_END);
        active      = h_act && v_act;
        x           = active ? COORD_W'(h_rel) : '0;
        y           = active ? COORD_W'(v_rel) : '0;
        frame_first = active && (h_rel == '0) && (v_rel == '0);
    end

endmodule

`default_nettype wire

// File: rtl/lcd_timing_gen.sv
// ============================================================================
//  Module      : lcd_timing_gen
//  Description : RGB LCD timing generator: issues pixel fetches and drives
//                registered panel pins aligned to the returned pixel data.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BACK   = H_BACK_DEF,
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   H_FRONT  = H_FRONT_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BACK   = V_BACK_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   V_FRONT  = V_FRONT_DEF,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   COORD_W  = COORD_W_DEF
) (
    input  logic               lcd_clk,
    input  logic               lcd_rst,
    output logic               pixel_req,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    input  logic [23:0]        pixel_data,
    output logic               frame_start,
    output logic               lcd_bl,
    output logic [23:0]        lcd_rgb,
    output logic               lcd_hs,
    output logic               lcd_vs,
    output logic               lcd_de
);

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_ACTIVE - 1);
    localparam lcd_pins_t PINS_IDLE = '{hs: ~HS_POL, vs: ~VS_POL, de: 1'b0, rgb: '0};

    logic               w_hsync, w_vsync, w_active, w_frame_first;
    logic [COORD_W-1:0] w_x, w_y;

    logic               req_q, req_d, fs_q, fs_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    lcd_pins_t          s1_q, s1_d, s2_q, s2_d, pins_q, pins_d;
    logic               last1_q, last1_d, last2_q, last2_d, last3_q, last3_d;
    logic               bl_q, bl_d;

    lcd_sync_counter #(
        .H_SYNC   (H_SYNC),
        .H_BACK   (H_BACK),
        .H_ACTIVE (H_ACTIVE),
        .H_FRONT  (H_FRONT),
        .V_SYNC   (V_SYNC),
        .V_BACK   (V_BACK),
        .V_ACTIVE (V_ACTIVE),
        .V_FRONT  (V_FRONT),
        .COORD_W  (COORD_W)
    ) u_sync_counter (
        .lcd_clk     (lcd_clk),
        .lcd_rst     (lcd_rst),
        .hsync       (w_hsync),
        .vsync       (w_vsync),
        .active      (w_active),
        .x           (w_x),
        .y           (w_y),
        .frame_first (w_frame_first)
    );

    always_ff @(posedge lcd_clk) begin
        if (lcd_rst) begin
            req_q   <= 1'b0;
            fs_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            s1_q    <= PINS_IDLE;
            s2_q    <= PINS_IDLE;
            pins_q  <= PINS_IDLE;
            last1_q <= 1'b0;
            last2_q <= 1'b0;
            last3_q <= 1'b0;
            bl_q    <= 1'b0;
        end else begin
            req_q   <= req_d;
            fs_q    <= fs_d;
            x_q     <= x_d;
            y_q     <= y_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            pins_q  <= pins_d;
            last1_q <= last1_d;
            last2_q <= last2_d;
            last3_q <= last3_d;
            bl_q    <= bl_d;
        end
    end

    always_comb begin
        req_d   = w_active;
        fs_d    = w_frame_first;
        x_d     = w_x;
        y_d     = w_y;
        s1_d.hs  = w_hsync ? HS_POL : ~HS_POL;
        s1_d.vs  = w_vsync ? VS_POL : ~VS_POL;
        s1_d.de  = w_active;
        s1_d.rgb = '0;
        last1_d = w_active && (w_x == X_LAST) && (w_y == Y_LAST);

        s2_d    = s1_q;
        last2_d = last1_q;

        // Source data arrives during S2; blanking colour rides the pipe otherwise.
        pins_d     = s2_q;
        pins_d.rgb = s2_q.de ? pixel_data : s2_q.rgb;
        last3_d    = last2_q;

        // Backlight arms once the final pixel of a full frame has left the pins.
        bl_d = bl_q | last3_q;
    end

    assign pixel_req   = req_q;
    assign pixel_x     = x_q;
    assign pixel_y     = y_q;
    assign frame_start = fs_q;
    assign lcd_hs      = pins_q.hs;
    assign lcd_vs      = pins_q.vs;
    assign lcd_de      = pins_q.de;
    assign lcd_rgb     = pins_q.rgb;
    assign lcd_bl      = bl_q;

endmodule

`default_nettype wire

// File: doc/lcd_timing_gen.md
# lcd_timing_gen

Video timing generator and pixel-fetch front end for the RGB LCD path inside `lcd_display`. It runs on `lcd_clk` and sweeps horizontal and vertical counters. For each active pixel it issues a coordinate request to the pixel source, then drives the registered panel pins `lcd_hs`, `lcd_vs`, `lcd_de`, `lcd_rgb` and `lcd_bl` with the sync signals aligned to the returned pixel data. The `lcd_display` pin monitor consumes its outputs directly.

## Interface
Parameters:
- `H_SYNC`, 128, hsync width in clocks
- `H_BACK`, 88, horizontal back porch
- `H_ACTIVE`, 800, active pixels per line
- `H_FRONT`, 40, horizontal front porch
- `V_SYNC`, 2, vsync width in lines
- `V_BACK`, 33, vertical back porch
- `V_ACTIVE`, 480, active lines
- `V_FRONT`, 10, vertical front porch
- `HS_POL`, 0, hsync active level
- `VS_POL`, 0, vsync active level
- `COORD_W`, 11, width of pixel_x/pixel_y

Ports:
- `lcd_clk` in 1: pixel clock, the single clock; all logic rises on it
- `lcd_rst` in 1: synchronous, active-high reset
- `pixel_req` out 1: pixel fetch strobe for (pixel_x, pixel_y)
- `pixel_x` out COORD_W: active-area column, 0..H_ACTIVE-1
- `pixel_y` out COORD_W: active-area row, 0..V_ACTIVE-1
- `pixel_data` in 24: RGB888 from source, fixed 1-cycle latency
- `frame_start` out 1: one-cycle pulse at the first request of each frame
- `lcd_bl` out 1: backlight enable
- `lcd_rgb` out 24: pixel to panel
- `lcd_hs` out 1: hsync
- `lcd_vs` out 1: vsync
- `lcd_de` out 1: data enable

## Operation
- H_TOTAL = H_SYNC+H_BACK+H_ACTIVE+H_FRONT. V_TOTAL is the analogue.
- `h_cnt` counts 0..H_TOTAL-1 and wraps to 0. `v_cnt` increments on each h wrap and wraps 0 after V_TOTAL-1. The two wraps occur in the same cycle at frame end.
- Sync is active while `h_cnt < H_SYNC` (hsync) and `v_cnt < V_SYNC` (vsync). Sync timing is counted from 0, so sync comes first, then back porch, then active, then front porch.
- Active region: `h_cnt` in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE) AND `v_cnt` in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_ACTIVE).
- `pixel_x` = h_cnt-(H_SYNC+H_BACK) and `pixel_y` = v_cnt-(V_SYNC+V_BACK), both zero-extended to COORD_W. Outside active they hold 0.
- `lcd_rgb` = captured `pixel_data` when `lcd_de`=1, else 24'h0. `pixel_data` is ignored when no request was made.
- Backlight: `lcd_bl` stays 0 after reset until the first complete frame has been emitted, which is the cycle after the last pixel of frame 0 leaves `lcd_de`. It then stays 1 until reset.
- `frame_start` pulses with the pixel_req for (0,0).

## Timing
- Pipeline: counters (S0), then registered request stage (S1: `pixel_req`, `pixel_x`, `pixel_y`, `frame_start`, delayed hs/vs/de), then S2 delay, then registered pin stage S3.
- `pixel_req` in cycle k implies `pixel_data` is valid in cycle k+1. `lcd_de`=1 and `lcd_rgb` carry that pixel in cycle k+2.
- `lcd_hs`/`lcd_vs`/`lcd_de` are delayed by the same amount, so the pins are mutually aligned.
- Reset values:
  - counters 0
  - `pixel_req`=0, `pixel_x`=0, `pixel_y`=0, `frame_start`=0
  - `lcd_rgb`=0, `lcd_de`=0, `lcd_bl`=0
  - `lcd_hs`=!HS_POL, `lcd_vs`=!VS_POL (inactive levels)
- Reset mid-frame: every pipeline stage clears in the same edge. The first `lcd_hs` active level appears 3 cycles after reset deasserts, because S0 starts at h_cnt=0. `lcd_bl` drops to 0 and re-arms.
- No back-pressure. The source must meet the 1-cycle latency unconditionally.

## Structure
- Package `lcd_timing_pkg` holds:
  - default timing constants (800x480)
  - `typedef logic [23:0] rgb_t`
  - a `lcd_pins_t` struct (`hs`, `vs`, `de`, `rgb`) used by S2/S3 and by verification monitors
- Sub-module `lcd_sync_counter` holds the h/v counter pair plus region decode. Its outputs are `hsync`, `vsync`, `active`, `x`, `y` and `frame_first`, all combinational from the counters. The top keeps the S1–S3 registers and the backlight logic.

## Test plan
The bench uses small parameters: H 2/2/4/2 (H_TOTAL=10), V 1/1/3/1 (V_TOTAL=6), HS_POL=VS_POL=0, 60-cycle frame. The source returns {8'h0, y, x} packed per pixel, one cycle after request.
- Reset held 5 cycles, then released → `lcd_hs`=1, `lcd_vs`=1, `lcd_de`=0, `lcd_rgb`=0 and `lcd_bl`=0 while in reset. `lcd_hs`=0 and `lcd_vs`=0 in cycles 3–4 after release.
- Free run one frame → exactly 12 `pixel_req` pulses, at x 0..3 and y 0..2. `lcd_de` is high 4 consecutive cycles on each of 3 lines. Each rgb equals the requested {y, x}, 2 cycles after its request.
- `frame_start` → one pulse per 60 cycles, coincident with the request for (0,0).
- Backlight → `lcd_bl` rises the cycle after the 12th `lcd_de` of frame 0 and stays 1 across frames 1–2.
- Reset asserted mid-line 2 for 1 cycle → all outputs return to reset values on the next edge, and `lcd_bl`=0 until the next complete frame. The post-reset sequence matches scenario 1.
- Source drives 24'hFFFFFF continuously → `lcd_rgb`=0 whenever `lcd_de`=0, including the porches and sync.
